// File: rtl/snes_poller.sv
// SNES controller poller: one start pulse yields latch, 16 shift clocks, then a 16-bit pressed mask.
// valid arrives LATCH_CYCLES + 33*HALF_CYCLES + 1 cycles after start; start is ignored until back in IDLE (no backpressure).
module snes_poller #(
   parameter int LATCH_CYCLES = 12,
   parameter int HALF_CYCLES  = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        snes_data,
   output logic        snes_latch,
   output logic        snes_clk,
   output logic        busy,
   output logic        valid,
   output logic [15:0] state
);
   localparam int MAX_CYCLES = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LOAD  = CW'(HALF_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LATCH, GAP, CLK_LOW, CLK_HIGH, DONE} fsm_t;

   fsm_t          fsm_q, fsm_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [15:0]   shift_q, shift_d;
   logic [15:0]   state_q, state_d;
   logic          sync1_q, sync2_q;
   logic          phase_end;

   // Pad data idles high (released), so the synchronizer resets to 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= snes_data;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         state_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         state_q <= state_d;
      end
   end

   assign phase_end = (cnt_q == '0);

   always_comb begin
      fsm_d      = fsm_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      state_d    = state_q;
      snes_latch = 1'b0;
      snes_clk   = 1'b1;
      busy       = 1'b1;
      valid      = 1'b0;
      unique case (fsm_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               fsm_d = LATCH;
               cnt_d = LATCH_LOAD;
            end
         end
         LATCH: begin
            snes_latch = 1'b1;
            if (phase_end) begin
               fsm_d = GAP;
               cnt_d = HALF_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (phase_end) begin
               shift_d = {~sync2_q, shift_q[15:1]};
               fsm_d   = CLK_LOW;
               cnt_d   = HALF_LOAD;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         CLK_LOW: begin
            snes_clk = 1'b0;
            if (phase_end) begin
               fsm_d = CLK_HIGH;
               cnt_d = HALF_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         CLK_HIGH: begin
            // The 16th high phase has nothing left to sample; the mask is complete.
            if (phase_end) begin
               if (bit_q == 4'd15) begin
                  fsm_d   = DONE;
                  state_d = shift_q;
                  cnt_d   = '0;
               end else begin
                  shift_d = {~sync2_q, shift_q[15:1]};
                  bit_d   = bit_q + 4'd1;
                  fsm_d   = CLK_LOW;
                  cnt_d   = HALF_LOAD;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            busy  = 1'b0;
            valid = 1'b1;
            fsm_d = IDLE;
            cnt_d = '0;
         end
         default: begin
            busy  = 1'b0;
            fsm_d = IDLE;
            cnt_d = '0;
         end
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_snes_poller.sv
// Bench for snes_poller: pad models on two instances (default and minimum timing), scoreboard on valid.
module tb_snes_poller;
   localparam int L1 = 12;
   localparam int H1 = 6;
   localparam int L2 = 1;
   localparam int H2 = 3;

   logic clk = 1'b0;
   logic rst_n;
   logic start1, start2;
   logic data1, data2;
   logic latch1, latch2, sclk1, sclk2, busy1, busy2, valid1, valid2;
   logic [15:0] state1, state2;
   logic [15:0] raw1 = 16'hFFFF;
   logic [15:0] raw2 = 16'hFFFF;
   logic [15:0] pad1 = 16'hFFFF;
   logic [15:0] pad2 = 16'hFFFF;
   logic [15:0] q1[$];
   logic [15:0] q2[$];
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] raw;
      logic [15:0] exp_state;
   } vec_t;
   vec_t vecs[5];

   always #5 clk = ~clk;

   snes_poller dut (
      .clk(clk), .rst_n(rst_n), .start(start1), .snes_data(data1),
      .snes_latch(latch1), .snes_clk(sclk1), .busy(busy1), .valid(valid1), .state(state1)
   );

   snes_poller #(.LATCH_CYCLES(L2), .HALF_CYCLES(H2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .snes_data(data2),
      .snes_latch(latch2), .snes_clk(sclk2), .busy(busy2), .valid(valid2), .state(state2)
   );

   // Controller shift register: parallel load while latched, next bit on each rising shift clock.
   always @(posedge latch1 or posedge sclk1) begin
      if (latch1) pad1 <= raw1;
      else        pad1 <= {1'b1, pad1[15:1]};
   end
   always @(posedge latch2 or posedge sclk2) begin
      if (latch2) pad2 <= raw2;
      else        pad2 <= {1'b1, pad2[15:1]};
   end
   assign data1 = pad1[0];
   assign data2 = pad2[0];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   always @(negedge clk) begin
      if (valid1) begin
         if (q1.size() == 0) check("unexpected_valid1", 32'd1, 32'd0);
         else check("state1", {16'h0, state1}, {16'h0, q1.pop_front()});
      end
      if (valid2) begin
         if (q2.size() == 0) check("unexpected_valid2", 32'd1, 32'd0);
         else check("state2", {16'h0, state2}, {16'h0, q2.pop_front()});
      end
   end

   task automatic poll(input int which, input logic [15:0] raw, input logic [15:0] exp_state);
      int lc, hc, vc, n, bad, base;
      bit seen;
      logic l, c, b, v, el, ec, eb;
      lc = (which == 1) ? L1 : L2;
      hc = (which == 1) ? H1 : H2;
      vc = lc + 33 * hc + 1;
      base = lc + hc + 1;
      if (which == 1) begin raw1 = raw; q1.push_back(exp_state); end
      else begin raw2 = raw; q2.push_back(exp_state); end
      @(posedge clk); #1;
      if (which == 1) start1 = 1'b1; else start2 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      start2 = 1'b0;
      n = 1; seen = 0; bad = 0;
      while (!seen && n <= vc + 20) begin
         l = (which == 1) ? latch1 : latch2;
         c = (which == 1) ? sclk1 : sclk2;
         b = (which == 1) ? busy1 : busy2;
         v = (which == 1) ? valid1 : valid2;
         el = (n <= lc);
         ec = !(n >= base && n < base + 32 * hc && ((n - base) / hc) % 2 == 0);
         eb = (n < vc);
         if ({l, c, b} !== {el, ec, eb}) begin
            if (bad == 0) $display("first waveform difference at cycle %0d", n);
            bad++;
         end
         if (v) begin
            seen = 1;
            check("valid_cycle", n, vc);
         end else begin
            @(posedge clk); #1;
            n++;
         end
      end
      if (!seen) check("valid_timeout", 32'd0, 32'd1);
      check("waveform_diff_cycles", bad, 0);
      repeat (3) @(posedge clk);
      #1;
      check("state_hold", {16'h0, (which == 1) ? state1 : state2}, {16'h0, exp_state});
   endtask

   // Start pulses at 0, 50, 211 (DONE) and 212, or start held high throughout.
   task automatic seq(input bit held);
      int v_cnt, v_at0, v_at1;
      raw1 = 16'h0F0F;
      v_cnt = 0; v_at0 = -1; v_at1 = -1;
      @(posedge clk); #1;
      for (int n = 0; n <= 430; n++) begin
         start1 = held ? (n <= 422) : (n == 0 || n == 50 || n == 211 || n == 212);
         if (n == 0 || n == 212) q1.push_back(16'hF0F0);
         if (n == 212) check("idle_between_polls", {31'h0, busy1}, 32'd0);
         if (n == 213) check("second_poll_busy", {31'h0, busy1}, 32'd1);
         if (valid1) begin
            if (v_cnt == 0) v_at0 = n;
            else if (v_cnt == 1) v_at1 = n;
            v_cnt++;
         end
         @(posedge clk); #1;
      end
      start1 = 1'b0;
      check("seq_valid_count", v_cnt, 2);
      check("seq_first_valid", v_at0, 211);
      check("seq_second_valid", v_at1, 423);
   endtask

   initial begin
      int busy_cnt;
      vecs[0] = '{raw: 16'hFFFF, exp_state: 16'h0000};
      vecs[1] = '{raw: 16'hFFFE, exp_state: 16'h0001};
      vecs[2] = '{raw: 16'h5A3C, exp_state: 16'hA5C3};
      vecs[3] = '{raw: 16'h0000, exp_state: 16'hFFFF};
      vecs[4] = '{raw: 16'h7FFF, exp_state: 16'h8000};

      rst_n = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs1", {valid1, busy1, sclk1, latch1, state1}, {4'b0010, 16'h0});
      check("rst_outputs2", {valid2, busy2, sclk2, latch2, state2}, {4'b0010, 16'h0});
      rst_n = 1'b1;

      busy_cnt = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (busy1 || busy2) busy_cnt++;
      end
      check("no_poll_without_start", busy_cnt, 0);

      for (int i = 0; i < 5; i++) poll(1, vecs[i].raw, vecs[i].exp_state);
      poll(2, 16'h8001, 16'h7FFE);
      poll(2, 16'h5A3C, 16'hA5C3);

      seq(1'b0);
      seq(1'b1);

      // Reset at cycle 100 of a poll.
      raw1 = 16'h1234;
      q1.push_back(16'hEDCB);
      @(posedge clk); #1;
      for (int n = 0; n < 100; n++) begin
         start1 = (n == 0);
         if (n == 99) check("busy_before_reset", {31'h0, busy1}, 32'd1);
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("midpoll_rst_outputs", {valid1, busy1, sclk1, latch1, state1}, {4'b0010, 16'h0});
      q1.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      busy_cnt = 0;
      repeat (300) begin
         @(posedge clk); #1;
         if (busy1) busy_cnt++;
      end
      check("no_poll_after_reset", busy_cnt, 0);
      poll(1, 16'h1234, 16'hEDCB);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
